nodf_module_intf: RTL and testbench
===================================

NODF_MODULE_INTF -- requirements
Module: nodf_module_intf

Interface
REQ-001 Parameter CNT_W, default 32: width of every counter and statistic output.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ap_start  input  1  start request of the monitored non-dataflow module.
REQ-005 ap_ready  input  1  monitored module's input-accepted strobe.
REQ-006 ap_done  input  1  monitored module's completion strobe.
REQ-007 ap_continue  input  1  downstream acknowledge of ap_done; tie to 1 when unused.
REQ-008 finish  input  1  end-of-simulation/end-of-run marker.
REQ-009 busy  output  1  transaction outstanding (state BUSY or DONE_HOLD).
REQ-010 finished  output  1  state FINISHED.
REQ-011 txn_count  output  CNT_W  completed transactions.
REQ-012 last_latency, min_latency, max_latency  output  CNT_W each  latency statistics in cycles.
REQ-013 last_interval  output  CNT_W  cycles between the last two transaction begins.
REQ-014 ready_count  output  CNT_W  cycles with ap_start=1 and ap_ready=1.
REQ-015 protocol_err  output  1  sticky protocol-violation flag.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY, DONE_HOLD, FINISHED.
REQ-017 Begin: ap_start=1 in IDLE; the latency counter loads 1 and the interval counter restarts.
REQ-018 In the begin cycle: ap_done=1 and ap_continue=1 completes with latency 1 and stays IDLE; ap_done=1 and ap_continue=0 records and goes to DONE_HOLD; otherwise go to BUSY.
REQ-019 In BUSY, the latency counter increments each cycle; ap_done=1 records and goes to IDLE if ap_continue=1, else to DONE_HOLD.
REQ-020 DONE_HOLD SHALL go to IDLE on ap_continue=1; repeated ap_done there SHALL NOT record again.
REQ-021 Record: txn_count+1; last_latency=value incl. current cycle; min/max updated with it.
REQ-022 Latency = done cycle - begin cycle + 1.
REQ-023 last_interval SHALL update at every begin except the first since reset: cycles since the previous begin.
REQ-024 ap_done=1 in IDLE without ap_start, or ap_ready=1 with ap_start=0, SHALL set protocol_err until reset.
REQ-025 finish=1 SHALL move any state to FINISHED (terminal until reset); a record due in that same cycle is still performed; nothing updates in FINISHED.
REQ-026 All counters SHALL saturate at all-ones; no wrap.
REQ-027 ready_count increments in every non-FINISHED cycle with ap_start=ap_ready=1.

Reset
REQ-028 Reset SHALL force IDLE; busy=0, finished=0, protocol_err=0, txn_count=0, last_latency=0, max_latency=0, last_interval=0, ready_count=0, min_latency=all-ones, internal counters cleared.
REQ-029 Reset mid-transaction SHALL discard the open transaction without recording it.

Structure
REQ-030 A shared package SHALL hold the state enum and the CNT_W default.
REQ-031 One sub-module, nodf_sat_counter (saturating counter: clear/load/increment), SHALL be reused for all counters.

Verification
REQ-032 Begin at cycle 10, ap_done at cycle 14, ap_continue=1 -> txn_count=1, last/min/max_latency=5, busy 0 after cycle 14.
REQ-033 ap_start with ap_done=ap_continue=1 in the same cycle -> latency 1, state stays IDLE.
REQ-034 ap_done at cycle 20, ap_continue low until cycle 23 -> one record, busy=1 through cycle 23, IDLE at cycle 24.
REQ-035 Begins at cycles 5 and 17, latencies 4 then 7 -> last_interval=12, min_latency=4, max_latency=7.
REQ-036 ap_done pulse in IDLE with ap_start=0 -> protocol_err=1, txn_count unchanged; cleared only by reset.
REQ-037 finish=1 during BUSY -> finished=1; later ap_done ignored; reset -> all REQ-028 values.

Source files
------------

// File: rtl/nodf_module_intf_pkg.sv
// Shared types and defaults for the non-dataflow handshake monitor.
package nodf_module_intf_pkg;

   localparam int unsigned CntWDefault = 32;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDoneHold,
      StFinished
   } nodf_state_e;

endpackage

// File: rtl/nodf_sat_counter.sv
// Saturating counter with clear, load and increment; clear wins over load, load over increment.
module nodf_sat_counter #(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             inc_i,
   output logic [Width-1:0] q_o
);

   localparam logic [Width-1:0] One = Width'(1);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + One;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q_o = cnt_q;

endmodule

// File: rtl/nodf_module_intf.sv
// Monitors the ap_start/ap_ready/ap_done/ap_continue handshake of a non-dataflow block and
// collects transaction count, latency, interval and protocol statistics.
module nodf_module_intf
   import nodf_module_intf_pkg::*;
#(
   parameter int unsigned CNT_W = CntWDefault
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   input  logic             ap_continue,
   input  logic             finish,
   output logic             busy,
   output logic             finished,
   output logic [CNT_W-1:0] txn_count,
   output logic [CNT_W-1:0] last_latency,
   output logic [CNT_W-1:0] min_latency,
   output logic [CNT_W-1:0] max_latency,
   output logic [CNT_W-1:0] last_interval,
   output logic [CNT_W-1:0] ready_count,
   output logic             protocol_err
);

   localparam logic [CNT_W-1:0] One = CNT_W'(1);

   nodf_state_e state_q, state_d;

   logic [CNT_W-1:0] lat_q, ival_q;
   logic [CNT_W-1:0] lat_cur;
   logic [CNT_W-1:0] rec_lat;
   logic [CNT_W-1:0] last_lat_q, min_lat_q, max_lat_q, last_ival_q;
   logic             seen_begin_q, perr_q;
   logic             active, begin_txn, record, perr_set;

   assign active    = (state_q != StFinished);
   assign begin_txn = (state_q == StIdle) && ap_start;
   // Latency including the current cycle, held at all-ones once saturated.
   assign lat_cur   = (lat_q == '1) ? lat_q : lat_q + One;
   assign perr_set  = active && ((ap_ready && !ap_start) ||
                                 ((state_q == StIdle) && ap_done && !ap_start));

   always_comb begin
      state_d = state_q;
      record  = 1'b0;
      rec_lat = lat_cur;
      unique case (state_q)
         StIdle: begin
            if (ap_start) begin
               if (ap_done) begin
                  record  = 1'b1;
                  rec_lat = One;
                  state_d = ap_continue ? StIdle : StDoneHold;
               end else begin
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            if (ap_done) begin
               record  = 1'b1;
               state_d = ap_continue ? StIdle : StDoneHold;
            end
         end
         StDoneHold: begin
            if (ap_continue) begin
               state_d = StIdle;
            end
         end
         StFinished: begin
            state_d = StFinished;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (finish) begin
         state_d = StFinished;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         last_lat_q   <= '0;
         min_lat_q    <= '1;
         max_lat_q    <= '0;
         last_ival_q  <= '0;
         seen_begin_q <= 1'b0;
         perr_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (record) begin
            last_lat_q <= rec_lat;
            if (rec_lat < min_lat_q) begin
               min_lat_q <= rec_lat;
            end
            if (rec_lat > max_lat_q) begin
               max_lat_q <= rec_lat;
            end
         end
         if (begin_txn) begin
            seen_begin_q <= 1'b1;
            if (seen_begin_q) begin
               last_ival_q <= ival_q;
            end
         end
         if (perr_set) begin
            perr_q <= 1'b1;
         end
      end
   end

   nodf_sat_counter #(.Width(CNT_W)) u_lat_cnt (
      .clk_i      (clock),
      .rst_i      (reset),
      .clear_i    (1'b0),
      .load_i     (begin_txn),
      .load_val_i (One),
      .inc_i      (state_q == StBusy),
      .q_o        (lat_q)
   );

   // Loaded with 1 at a begin so that it reads the full begin-to-begin distance next time.
   nodf_sat_counter #(.Width(CNT_W)) u_ival_cnt (
      .clk_i      (clock),
      .rst_i      (reset),
      .clear_i    (1'b0),
      .load_i     (begin_txn),
      .load_val_i (One),
      .inc_i      (active && seen_begin_q),
      .q_o        (ival_q)
   );

   nodf_sat_counter #(.Width(CNT_W)) u_txn_cnt (
      .clk_i      (clock),
      .rst_i      (reset),
      .clear_i    (1'b0),
      .load_i     (1'b0),
      .load_val_i ('0),
      .inc_i      (record),
      .q_o        (txn_count)
   );

   nodf_sat_counter #(.Width(CNT_W)) u_rdy_cnt (
      .clk_i      (clock),
      .rst_i      (reset),
      .clear_i    (1'b0),
      .load_i     (1'b0),
      .load_val_i ('0),
      .inc_i      (active && ap_start && ap_ready),
      .q_o        (ready_count)
   );

   assign busy          = (state_q == StBusy) || (state_q == StDoneHold);
   assign finished      = (state_q == StFinished);
   assign last_latency  = last_lat_q;
   assign min_latency   = min_lat_q;
   assign max_latency   = max_lat_q;
   assign last_interval = last_ival_q;
   assign protocol_err  = perr_q;

endmodule

// File: tb/tb_nodf_module_intf.sv
// Self-checking bench: directed handshake scenarios plus random traffic against a
// transaction-level model built from begin/done cycle numbers.
module tb_nodf_module_intf;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0;
   logic        finish = 1'b0;
   logic        busy, finished, protocol_err;
   logic [31:0] txn_count, last_latency, min_latency, max_latency, last_interval, ready_count;

   nodf_module_intf #(.CNT_W(32)) dut (
      .clock         (clock),
      .reset         (reset),
      .ap_start      (ap_start),
      .ap_ready      (ap_ready),
      .ap_done       (ap_done),
      .ap_continue   (ap_continue),
      .finish        (finish),
      .busy          (busy),
      .finished      (finished),
      .txn_count     (txn_count),
      .last_latency  (last_latency),
      .min_latency   (min_latency),
      .max_latency   (max_latency),
      .last_interval (last_interval),
      .ready_count   (ready_count),
      .protocol_err  (protocol_err)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Model: a transaction is either open (waiting for done) or held (done seen, no continue).
   int          cyc;
   int          m_begin;
   bit          m_open, m_hold, m_fin, m_seen, m_perr;
   logic [31:0] m_txn, m_last, m_min, m_max, m_ival, m_rdy;

   task automatic model_reset();
      cyc = 0; m_begin = 0;
      m_open = 0; m_hold = 0; m_fin = 0; m_seen = 0; m_perr = 0;
      m_txn = 0; m_last = 0; m_min = 32'hFFFF_FFFF; m_max = 0; m_ival = 0; m_rdy = 0;
   endtask

   task automatic model_record(input int lat);
      m_txn++;
      m_last = lat;
      if (lat < m_min) m_min = lat;
      if (lat > m_max) m_max = lat;
   endtask

   task automatic model_step(input bit s, input bit r, input bit d, input bit c, input bit f);
      cyc++;
      if (m_fin) return;
      if (s && r) m_rdy++;
      if (!s && r) m_perr = 1;
      if (!m_open && !m_hold) begin
         if (s) begin
            if (m_seen) m_ival = cyc - m_begin;
            m_seen  = 1;
            m_begin = cyc;
            if (d) begin
               model_record(1);
               m_hold = !c;
            end else begin
               m_open = 1;
            end
         end else if (d) begin
            m_perr = 1;
         end
      end else if (m_open) begin
         if (d) begin
            model_record(cyc - m_begin + 1);
            m_open = 0;
            m_hold = !c;
         end
      end else if (c) begin
         m_hold = 0;
      end
      if (f) begin
         m_fin = 1; m_open = 0; m_hold = 0;
      end
   endtask

   task automatic check_all();
      check("busy", busy, m_open || m_hold);
      check("finished", finished, m_fin);
      check("txn_count", txn_count, m_txn);
      check("last_latency", last_latency, m_last);
      check("min_latency", min_latency, m_min);
      check("max_latency", max_latency, m_max);
      check("last_interval", last_interval, m_ival);
      check("ready_count", ready_count, m_rdy);
      check("protocol_err", protocol_err, m_perr);
   endtask

   task automatic step(input bit s, input bit r, input bit d, input bit c, input bit f);
      ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
      @(posedge clock);
      model_step(s, r, d, c, f);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
      @(posedge clock);
      @(posedge clock);
      #1;
      model_reset();
      check_all();
      reset = 1'b0;
   endtask

   logic [31:0] rdy_snap;

   initial begin
      model_reset();

      // Begin at 10, done at 14 with continue.
      do_reset();
      idle(9);
      step(1, 1, 0, 0, 0);
      idle(3);
      step(0, 0, 1, 1, 0);
      check("a_txn", txn_count, 1);
      check("a_last", last_latency, 5);
      check("a_min", min_latency, 5);
      check("a_max", max_latency, 5);
      check("a_busy", busy, 0);

      // Start, done and continue in one cycle.
      step(1, 1, 1, 1, 0);
      check("b_busy", busy, 0);
      check("b_last", last_latency, 1);
      check("b_min", min_latency, 1);
      check("b_txn", txn_count, 2);

      // Done at 20, continue held low until 23; repeated done in hold ignored.
      do_reset();
      idle(15);
      step(1, 1, 0, 0, 0);
      idle(3);
      step(0, 0, 1, 0, 0);
      check("c_busy20", busy, 1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      check("c_busy22", busy, 1);
      check("c_txn22", txn_count, 1);
      step(0, 0, 0, 1, 0);
      check("c_busy23", busy, 0);
      check("c_txn23", txn_count, 1);
      check("c_last", last_latency, 5);

      // Begins at 5 and 17, latencies 4 and 7.
      do_reset();
      idle(4);
      step(1, 1, 0, 0, 0);
      idle(2);
      step(0, 0, 1, 1, 0);
      idle(8);
      step(1, 1, 0, 0, 0);
      idle(5);
      step(0, 0, 1, 1, 0);
      check("d_ival", last_interval, 12);
      check("d_min", min_latency, 4);
      check("d_max", max_latency, 7);

      // Stray done in idle is a sticky protocol error.
      step(0, 0, 1, 0, 0);
      check("e_perr", protocol_err, 1);
      check("e_txn", txn_count, 2);
      idle(3);
      check("e_sticky", protocol_err, 1);

      // Finish during busy freezes everything until reset.
      step(1, 1, 0, 0, 0);
      idle(2);
      step(0, 0, 0, 0, 1);
      check("f_fin", finished, 1);
      check("f_busy", busy, 0);
      rdy_snap = ready_count;
      step(0, 0, 1, 1, 0);
      step(1, 1, 0, 0, 0);
      check("f_txn", txn_count, 2);
      check("f_rdy", ready_count, rdy_snap);
      do_reset();
      check("r_fin", finished, 0);
      check("r_perr", protocol_err, 0);
      check("r_txn", txn_count, 0);
      check("r_min", min_latency, 32'hFFFF_FFFF);
      check("r_ival", last_interval, 0);

      // Random traffic with occasional resets, finishes and protocol faults.
      for (int i = 0; i < 3000; i++) begin
         bit s, r, d, c, f;
         if ($urandom_range(0, 249) == 0) do_reset();
         s = ($urandom_range(0, 9) < 3);
         r = s ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 79) == 0);
         d = ($urandom_range(0, 9) < 3);
         if (!s && !busy && $urandom_range(0, 19) != 0) d = 0;
         c = ($urandom_range(0, 9) < 7);
         f = ($urandom_range(0, 599) == 0);
         step(s, r, d, c, f);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
